// File: rtl/xor_share_arb.sv
// Round-robin arbiter/sequencer sharing one external W-bit XOR unit among NREQ requesters.
// Optional build macro XOR_SHARE_ARB_CHECK_EN adds a result comparator with sticky chk_err output.
module xor_share_arb #(
    parameter int NREQ = 4,
    parameter int W    = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*W-1:0]        req_a,
    input  logic [NREQ*W-1:0]        req_b,
    output logic [W-1:0]             dp_a,
    output logic [W-1:0]             dp_b,
    input  logic [W-1:0]             dp_y,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [W-1:0]             rsp_y,
    output logic                     busy
`ifdef XOR_SHARE_ARB_CHECK_EN
    ,
    output logic                     chk_err
`endif
);

    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_EVAL = 2'd1, S_RESP = 2'd2} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, id_q;
    logic [IDW-1:0] win_idx, cand_idx;
    logic           win_found;
    logic           accept;
    logic [W-1:0]   dp_a_q, dp_b_q, rsp_y_q;
    logic           rsp_valid_q;
    int             cand;

    // Rotating-priority search: first valid requester at or after ptr_q.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            cand_idx = cand[IDW-1:0];
            if (!win_found && req_valid[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    assign accept = |(req_valid & req_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept)    state_d = S_EVAL;
            S_EVAL:                 state_d = S_RESP;
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    // rst gates the grant combinationally so nothing is accepted while reset is held.
    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && win_found && !rst) req_ready[win_idx] = 1'b1;
        busy = (state_q != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            id_q        <= '0;
            dp_a_q      <= '0;
            dp_b_q      <= '0;
            rsp_y_q     <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                dp_a_q <= req_a[win_idx*W +: W];
                dp_b_q <= req_b[win_idx*W +: W];
                id_q   <= win_idx;
            end
            if (state_q == S_EVAL) begin
                rsp_y_q     <= dp_y;
                rsp_valid_q <= 1'b1;
            end
            if (state_q == S_RESP && rsp_ready) begin
                rsp_valid_q <= 1'b0;
                ptr_q       <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
            end
        end
    end

    assign dp_a      = dp_a_q;
    assign dp_b      = dp_b_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;

`ifdef XOR_SHARE_ARB_CHECK_EN
    logic chk_err_q;

    // Sticky: any EVAL-cycle disagreement with a local XOR latches until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                               chk_err_q <= 1'b0;
        else if (state_q == S_EVAL && dp_y != (dp_a_q ^ dp_b_q)) chk_err_q <= 1'b1;
    end

    assign chk_err = chk_err_q;
`endif

endmodule

// File: tb/tb_xor_share_arb.sv
// Self-checking bench for xor_share_arb: directed steps plus randomized arbitration against a
// transaction-level round-robin model. Also exercises chk_err when XOR_SHARE_ARB_CHECK_EN is defined.
module tb_xor_share_arb;

    localparam int NREQ = 4;
    localparam int W    = 3;
    localparam int IDW  = 2;
    localparam int AW   = NREQ * W;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_ready;
    logic [AW-1:0]   req_a, req_b;
    logic [W-1:0]    dp_a, dp_b, dp_y;
    logic            rsp_valid, rsp_ready;
    logic [IDW-1:0]  rsp_id;
    logic [W-1:0]    rsp_y;
    logic            busy;
    logic            force_zero = 1'b0;
`ifdef XOR_SHARE_ARB_CHECK_EN
    logic            chk_err;
`endif

    int n_pass  = 0;
    int n_total = 0;
    int ptr_m;
    int e, guard, stall;
    logic [W-1:0] ea, eb;

    always #5 clk = ~clk;

    // Model of the shared gate-level XOR unit, with a fault hook.
    assign dp_y = force_zero ? '0 : (dp_a ^ dp_b);

    xor_share_arb #(.NREQ(NREQ), .W(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .dp_a(dp_a), .dp_b(dp_b), .dp_y(dp_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_y(rsp_y),
        .busy(busy)
`ifdef XOR_SHARE_ARB_CHECK_EN
        , .chk_err(chk_err)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Requester served last has lowest priority: search starts one past it.
    function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [31:0] onehot(input int idx);
        return (idx < 0) ? 32'd0 : (32'd1 << idx);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, with all requesters asserting valid.
        rst = 1'b1; rsp_ready = 1'b0; req_valid = '1;
        req_a = AW'($urandom); req_b = AW'($urandom);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_rsp_y", 32'(rsp_y), 0);
        chk("rst_dp_a", 32'(dp_a), 0);
        chk("rst_dp_b", 32'(dp_b), 0);

        // First transaction on requester 2.
        rst = 1'b0; req_valid = 4'b0100; req_a = '0; req_b = '0;
        req_a[2*W +: W] = 3'b101; req_b[2*W +: W] = 3'b011;
        #1;
        chk("first_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        #1;
        chk("first_dp_a", 32'(dp_a), 32'b101);
        chk("first_dp_b", 32'(dp_b), 32'b011);
        chk("first_busy", 32'(busy), 1);
        chk("first_eval_valid", 32'(rsp_valid), 0);
        tick();
        chk("first_rsp_valid", 32'(rsp_valid), 1);
        chk("first_rsp_id", 32'(rsp_id), 2);
        chk("first_rsp_y", 32'(rsp_y), 32'b110);

        // Response stall: 10 cycles with rsp_ready low while everyone requests.
        req_valid = '1;
        for (int s = 0; s < 10; s++) begin
            req_a = AW'($urandom); req_b = AW'($urandom);
            tick();
            chk("stall_valid", 32'(rsp_valid), 1);
            chk("stall_id", 32'(rsp_id), 2);
            chk("stall_y", 32'(rsp_y), 32'b110);
            chk("stall_ready", 32'(req_ready), 0);
            chk("stall_busy", 32'(busy), 1);
        end
        rsp_ready = 1'b1;
        tick();
        chk("stall_release_valid", 32'(rsp_valid), 0);
        chk("stall_release_busy", 32'(busy), 0);
        chk("after2_ready", 32'(req_ready), 32'b1000);
        req_valid = '0;

        // Round robin from a fresh reset: all valid, order 0,1,2,3,0, 3 cycles each.
        rst = 1'b1; tick(); rst = 1'b0; ptr_m = 0;
        rsp_ready = 1'b1; req_valid = '1;
        for (int t = 0; t < 5; t++) begin
            req_a = AW'($urandom); req_b = AW'($urandom);
            #1;
            e = rr_pick(req_valid, ptr_m);
            chk("rr_order", 32'(e), 32'(t % NREQ));
            chk("rr_ready", 32'(req_ready), onehot(e));
            chk("rr_idle_valid", 32'(rsp_valid), 0);
            ea = req_a[e*W +: W]; eb = req_b[e*W +: W];
            tick();
            req_a = AW'($urandom); req_b = AW'($urandom);
            #1;
            chk("rr_dp_a_hold", 32'(dp_a), 32'(ea));
            tick();
            chk("rr_rsp_valid", 32'(rsp_valid), 1);
            chk("rr_rsp_id", 32'(rsp_id), 32'(e));
            chk("rr_rsp_y", 32'(rsp_y), 32'(ea ^ eb));
            tick();
            ptr_m = (e + 1) % NREQ;
        end

        // Randomized valid patterns, withdrawals and response stalls.
        for (int t = 0; t < 40; t++) begin
            e = -1; guard = 0;
            while (e < 0 && guard < 64) begin
                req_valid = NREQ'($urandom); req_a = AW'($urandom); req_b = AW'($urandom);
                rsp_ready = 1'b0;
                #1;
                e = rr_pick(req_valid, ptr_m);
                chk("rnd_ready", 32'(req_ready), onehot(e));
                chk("rnd_idle_busy", 32'(busy), 0);
                if (e >= 0) begin
                    ea = req_a[e*W +: W]; eb = req_b[e*W +: W];
                end
                tick();
                guard++;
            end
            if (e < 0) continue;
            req_valid = NREQ'($urandom); req_a = AW'($urandom); req_b = AW'($urandom);
            #1;
            chk("rnd_eval_ready", 32'(req_ready), 0);
            tick();
            chk("rnd_rsp_valid", 32'(rsp_valid), 1);
            chk("rnd_rsp_id", 32'(rsp_id), 32'(e));
            chk("rnd_rsp_y", 32'(rsp_y), 32'(ea ^ eb));
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                req_valid = NREQ'($urandom);
                tick();
                chk("rnd_stall_y", 32'(rsp_y), 32'(ea ^ eb));
                chk("rnd_stall_ready", 32'(req_ready), 0);
            end
            rsp_ready = 1'b1;
            tick();
            chk("rnd_done_valid", 32'(rsp_valid), 0);
            ptr_m = (e + 1) % NREQ;
        end

        // Reset while in EVAL discards the in-flight operation.
        rsp_ready = 1'b1; req_valid = 4'b0001;
        req_a = AW'($urandom) | AW'(1); req_b = AW'($urandom);
        tick();
        rst = 1'b1;
        #1;
        chk("evrst_rsp_valid", 32'(rsp_valid), 0);
        chk("evrst_busy", 32'(busy), 0);
        chk("evrst_dp_a", 32'(dp_a), 0);
        chk("evrst_dp_b", 32'(dp_b), 0);
        chk("evrst_req_ready", 32'(req_ready), 0);
        chk("evrst_rsp_id", 32'(rsp_id), 0);
        req_valid = '0;
        tick();
        rst = 1'b0; ptr_m = 0;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("evrst_no_rsp", 32'(rsp_valid), 0);
        end
        req_valid = 4'b1010; req_a = AW'($urandom); req_b = AW'($urandom);
        #1;
        e = rr_pick(req_valid, ptr_m);
        chk("evrst_fresh_ready", 32'(req_ready), onehot(e));
        ea = req_a[e*W +: W]; eb = req_b[e*W +: W];
        tick();
        req_valid = '0;
        tick();
        chk("evrst_fresh_id", 32'(rsp_id), 32'(e));
        chk("evrst_fresh_y", 32'(rsp_y), 32'(ea ^ eb));
        tick();

        // Exhaustive operand pairs on requester 1.
        for (int i = 0; i < 64; i++) begin
            req_valid = 4'b0010; req_a = AW'($urandom); req_b = AW'($urandom);
            req_a[1*W +: W] = W'(i >> 3); req_b[1*W +: W] = W'(i & 7);
            tick();
            req_valid = '0;
            tick();
            chk("exh_id", 32'(rsp_id), 1);
            chk("exh_y", 32'(rsp_y), 32'((i >> 3) ^ (i & 7)));
            tick();
        end
`ifdef XOR_SHARE_ARB_CHECK_EN
        chk("chk_err_clean", 32'(chk_err), 0);

        // Faulty shared unit: result forced to zero for a=111, b=000.
        force_zero = 1'b1;
        req_valid = 4'b0010; req_a = '0; req_b = '0; req_a[1*W +: W] = 3'b111;
        tick();
        req_valid = '0;
        tick();
        chk("fault_chk_err", 32'(chk_err), 1);
        chk("fault_rsp_y", 32'(rsp_y), 0);
        force_zero = 1'b0;
        repeat (4) tick();
        chk("fault_sticky", 32'(chk_err), 1);
        rst = 1'b1;
        #1;
        chk("fault_cleared", 32'(chk_err), 0);
        tick();
        rst = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
